// File: rtl/booth_radix4_seq_mul.sv
// Sequential radix-4 Booth multiplier: one digit per clock, N = WIDTH/2+1 cycles per product.
// Optional macro BOOTH_SKIP_ZERO_EN ends the run early once the remaining multiplier bits are zero.
module booth_radix4_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);
    localparam int N  = WIDTH / 2 + 1;
    localparam int IW = $clog2(N + 1);
    localparam int AW = 2 * WIDTH + 2;
    localparam int BW = WIDTH + 3;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [BW-1:0]    r_bx;
    logic [AW-1:0]    r_acc;
    logic [IW-1:0]    r_idx;

    logic [IW:0]      w_sh;
    logic [2:0]       w_win;
    logic [BW-1:0]    w_mag;
    logic [BW-1:0]    w_pp;
    logic             w_neg;
    logic [AW-1:0]    w_addend;
    logic             w_last;
    logic             w_finish;
    logic             w_unused;

    assign w_sh     = {r_idx, 1'b0};
    assign w_win    = r_bx[w_sh +: 3];
    assign w_last   = (r_idx == IW'(N - 1));
    assign out_p    = r_acc[2*WIDTH-1:0];
    assign w_unused = ^r_acc[AW-1:2*WIDTH];

    always_comb begin
        w_mag = '0;
        w_neg = 1'b0;
        case (w_win)
            3'b001, 3'b010: w_mag = {3'b000, r_a};
            3'b011:         w_mag = {2'b00, r_a, 1'b0};
            3'b100: begin
                w_mag = {2'b00, r_a, 1'b0};
                w_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                w_mag = {3'b000, r_a};
                w_neg = 1'b1;
            end
            default: begin
                w_mag = '0;
                w_neg = 1'b0;
            end
        endcase
        // Negative digits: one's complement here, the +1 rides in at the digit's own weight.
        w_pp     = w_neg ? ~w_mag : w_mag;
        w_addend = ({{(WIDTH-1){w_pp[BW-1]}}, w_pp} + AW'(w_neg)) << w_sh;
    end

`ifdef BOOTH_SKIP_ZERO_EN
    logic [IW:0] w_sh2;
    logic        w_rest_zero;
    always_comb begin
        w_sh2       = w_sh + (IW+1)'(2);
        w_rest_zero = ((r_bx >> w_sh2) == '0);
        w_finish    = w_last | w_rest_zero;
    end
`else
    assign w_finish = w_last;
`endif

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_finish) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_bx  <= '0;
            r_acc <= '0;
            r_idx <= '0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_a   <= in_a;
            r_bx  <= {2'b00, in_b, 1'b0};
            r_acc <= '0;
            r_idx <= '0;
        end else if (r_state == S_RUN) begin
            r_acc <= r_acc + w_addend;
            r_idx <= r_idx + IW'(1);
        end
    end
endmodule

// File: tb/tb_booth_radix4_seq_mul.sv
// Directed and randomised checks of booth_radix4_seq_mul at WIDTH=8.
module tb_booth_radix4_seq_mul;
    localparam int N = 5;
`ifdef BOOTH_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        int          lat_skip;
    } vec_t;

    vec_t vecs[11];

    booth_radix4_seq_mul #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int cnt);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick;
            cnt++;
        end
    endtask

    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_p, input int exp_lat);
        int cnt;
        cnt = 0;
        while (!in_ready && cnt < 20) begin
            tick;
            cnt++;
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick;
        in_valid = 1'b0;
        wait_out(cnt);
        if (exp_lat > 0) check({name, " latency"}, cnt, exp_lat);
        check({name, " out_valid"}, out_valid, 1);
        check({name, " product"}, out_p, exp_p);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    initial begin
        int cnt;
        int cyc;
        int k;
        int got;
        int acc_cyc[3];
        logic [7:0]  pa[3];
        logic [7:0]  pb[3];
        logic [15:0] pp[3];
        logic        acc_now;
        logic        out_now;
        logic [15:0] p_now;
        logic [7:0]  ra;
        logic [7:0]  rb;

        vecs[0]  = '{8'hFF, 8'hFF, 16'hFE01, 5};
        vecs[1]  = '{8'h80, 8'h02, 16'h0100, 2};
        vecs[2]  = '{8'h00, 8'hAB, 16'h0000, 5};
        vecs[3]  = '{8'h37, 8'h00, 16'h0000, 1};
        vecs[4]  = '{8'h5B, 8'h27, 16'h0DDD, 4};
        vecs[5]  = '{8'h03, 8'h05, 16'h000F, 2};
        vecs[6]  = '{8'h01, 8'h01, 16'h0001, 1};
        vecs[7]  = '{8'hAA, 8'h55, 16'h3872, 4};
        vecs[8]  = '{8'hFF, 8'h80, 16'h7F80, 5};
        vecs[9]  = '{8'h12, 8'h34, 16'h03A8, 4};
        vecs[10] = '{8'hFF, 8'h03, 16'h02FD, 2};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        tick;
        tick;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset out_p", out_p, 0);
        rst = 1'b0;
        tick;

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p,
                   SKIP ? vecs[i].lat_skip : N);
        end

        // Output held under back-pressure; a pending request waits for the drain.
        in_valid = 1'b1;
        in_a     = 8'h5B;
        in_b     = 8'h27;
        tick;
        in_a     = 8'h02;
        in_b     = 8'h03;
        check("hold busy after accept", busy, 1);
        wait_out(cnt);
        for (int c = 0; c < 10; c++) begin
            check($sformatf("hold%0d out_valid", c), out_valid, 1);
            check($sformatf("hold%0d out_p", c), out_p, 16'h0DDD);
            check($sformatf("hold%0d in_ready", c), in_ready, 0);
            tick;
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check("drain in_ready", in_ready, 1);
        check("drain out_valid", out_valid, 0);
        tick;
        in_valid = 1'b0;
        check("post-drain accept busy", busy, 1);
        wait_out(cnt);
        check("post-drain product", out_p, 16'h0006);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;

        // Back-to-back stream with the consumer always ready.
        pa[0] = 8'hFF; pb[0] = 8'hFF; pp[0] = 16'hFE01;
        pa[1] = 8'h12; pb[1] = 8'h9C; pp[1] = 16'h0AF8;
        pa[2] = 8'hC3; pb[2] = 8'h81; pp[2] = 16'h6243;
        k = 0;
        got = 0;
        cyc = 0;
        in_valid  = 1'b1;
        in_a      = pa[0];
        in_b      = pb[0];
        out_ready = 1'b1;
        while (got < 3 && cyc < 60) begin
            acc_now = in_valid & in_ready;
            out_now = out_valid;
            p_now   = out_p;
            tick;
            cyc++;
            if (acc_now) begin
                acc_cyc[k] = cyc;
                k++;
                if (k < 3) begin
                    in_a = pa[k];
                    in_b = pb[k];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_now) begin
                check($sformatf("b2b product%0d", got), p_now, pp[got]);
                got++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b accepts", k, 3);
        check("b2b transfers", got, 3);
        check("b2b spacing01", acc_cyc[1] - acc_cyc[0], N + 2);
        check("b2b spacing12", acc_cyc[2] - acc_cyc[1], N + 2);
        tick;

        // Reset in the second RUN cycle aborts the operation.
        in_valid = 1'b1;
        in_a     = 8'hFF;
        in_b     = 8'hFF;
        tick;
        in_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort out_valid", out_valid, 0);
        check("abort in_ready", in_ready, 1);
        check("abort busy", busy, 0);
        check("abort out_p", out_p, 0);
        run_op("after abort", 8'h03, 8'h05, 16'h000F, SKIP ? 2 : N);

        for (int r = 0; r < 2000; r++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op("rand", ra, rb, 16'(ra) * 16'(rb), SKIP ? 0 : N);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
